// File: rtl/cla_pkg.sv
// cla_pkg: shared group size, group generate/propagate type and group-count helper for the pipelined CLA.
package cla_pkg;
  localparam int GRP = 4;
  typedef struct packed {logic g; logic p;} gp_t;
  function automatic int group_count(input int width);
    return width / GRP;
  endfunction
endpackage

// File: rtl/cla_group4.sv
// cla_group4: 4-bit lookahead cell giving group generate/propagate and the in-group carries from ci.
module cla_group4
  import cla_pkg::*;
(
  input  logic [GRP-1:0] g,
  input  logic [GRP-1:0] p,
  input  logic           ci,
  output logic           gg,
  output logic           gp,
  output logic [GRP-1:0] c
);
  always_comb begin
    c[0] = ci;
    for (int i = 1; i < GRP; i++) c[i] = g[i-1] | p[i-1] & c[i-1];
    gg = g[3] | p[3] & g[2] | p[3] & p[2] & g[1] | p[3] & p[2] & p[1] & g[0];
    gp = &p;
  end
endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: two-stage valid/ready pipelined CLA adder/subtractor; CLA_FLAGS_EN adds ovf/zero outputs.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_FLAGS_EN
  ,
  output logic             ovf,
  output logic             zero
`endif
);
  localparam int NG = group_count(WIDTH);
  if (WIDTH % GRP != 0) begin : g_width_chk
    $error("cla_pipe_adder: WIDTH must be a multiple of 4");
  end
  logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, s1_adv, s2_adv, ld1, ld2;
  logic c0_q, c0_d, cout_q, cout_d;
  logic [WIDTH-1:0] bb, g_q, g_d, p_q, p_d, h_q, h_d, sum_q, sum_d, sum_n, ci, s1_c_unused;
  logic [NG-1:0] s1_gg, s1_gp, s2_gg_unused, s2_gp_unused;
  logic [NG:0] gc;
  gp_t [NG-1:0] grp_q, grp_d;
  assign bb = sub ? ~b : b;
  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla_group4 u_s1 (
      .g(a[4*k +: 4] & bb[4*k +: 4]), .p(a[4*k +: 4] | bb[4*k +: 4]), .ci(1'b0),
      .gg(s1_gg[k]), .gp(s1_gp[k]), .c(s1_c_unused[4*k +: 4])
    );
    cla_group4 u_s2 (
      .g(g_q[4*k +: 4]), .p(p_q[4*k +: 4]), .ci(gc[k]),
      .gg(s2_gg_unused[k]), .gp(s2_gp_unused[k]), .c(ci[4*k +: 4])
    );
  end
  // group carries ripple across the registered group terms
  always_comb begin
    gc[0] = c0_q;
    for (int k = 0; k < NG; k++) gc[k+1] = grp_q[k].g | grp_q[k].p & gc[k];
  end
  always_comb begin
    s2_adv = !s2_valid_q | out_ready;
    s1_adv = !s1_valid_q | s2_adv;
    ld1 = s1_adv & in_valid;
    ld2 = s2_adv & s1_valid_q;
    sum_n = h_q ^ ci;
    s1_valid_d = s1_adv ? in_valid : s1_valid_q;
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    g_d = ld1 ? a & bb : g_q;
    p_d = ld1 ? a | bb : p_q;
    h_d = ld1 ? a ^ bb : h_q;
    c0_d = ld1 ? (sub ? 1'b1 : cin) : c0_q;
    for (int k = 0; k < NG; k++) begin
      grp_d[k].g = ld1 ? s1_gg[k] : grp_q[k].g;
      grp_d[k].p = ld1 ? s1_gp[k] : grp_q[k].p;
    end
    sum_d = ld2 ? sum_n : sum_q;
    cout_d = ld2 ? gc[NG] : cout_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      g_q <= '0;
      p_q <= '0;
      h_q <= '0;
      c0_q <= 1'b0;
      grp_q <= '0;
      sum_q <= '0;
      cout_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      g_q <= g_d;
      p_q <= p_d;
      h_q <= h_d;
      c0_q <= c0_d;
      grp_q <= grp_d;
      sum_q <= sum_d;
      cout_q <= cout_d;
    end
  end
  assign in_ready = s1_adv;
  assign out_valid = s2_valid_q;
  assign sum = sum_q;
  assign cout = cout_q;
`ifdef CLA_FLAGS_EN
  logic am_q, am_d, bm_q, bm_d, ovf_q, ovf_d, zero_q, zero_d;
  always_comb begin
    am_d = ld1 ? a[WIDTH-1] : am_q;
    bm_d = ld1 ? bb[WIDTH-1] : bm_q;
    ovf_d = ld2 ? (am_q == bm_q) & (sum_n[WIDTH-1] != am_q) : ovf_q;
    zero_d = ld2 ? ~|sum_n : zero_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      am_q <= 1'b0;
      bm_q <= 1'b0;
      ovf_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      am_q <= am_d;
      bm_q <= bm_d;
      ovf_q <= ovf_d;
      zero_q <= zero_d;
    end
  end
  assign ovf = ovf_q;
  assign zero = zero_q;
`endif
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: directed and randomised checks of the pipelined CLA adder; flag checks under CLA_FLAGS_EN.
module tb_cla_pipe_adder;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
  logic [31:0] a, b, sum;
  int n_cmp = 0;
  int n_bad = 0;
`ifdef CLA_FLAGS_EN
  logic ovf, zero;
`endif
  always #5 clk = ~clk;
  cla_pipe_adder #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef CLA_FLAGS_EN
    , .ovf(ovf), .zero(zero)
`endif
  );

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (sum !== 32'h0) begin n_bad++; $display("FAIL reset_sum got %h want 0", sum); end
    n_cmp++; if (cout !== 1'b0) begin n_bad++; $display("FAIL reset_cout got %b want 0", cout); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
`ifdef CLA_FLAGS_EN
    n_cmp++; if ({ovf, zero} !== 2'b00) begin n_bad++; $display("FAIL reset_flags got %b want 00", {ovf, zero}); end
`endif
  endtask

  task automatic test_directed;
    logic [31:0] va[8] = '{32'h5, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h3, 32'h12345678, 32'hA, 32'hF, 32'h80000000};
    logic [31:0] vb[8] = '{32'h3, 32'h1, 32'h1, 32'h5, 32'h12345678, 32'h3, 32'h1, 32'h80000000};
    logic vc[8] = '{0, 0, 0, 0, 0, 1, 1, 0};
    logic vs[8] = '{0, 0, 0, 1, 1, 1, 0, 0};
    logic [31:0] es[8] = '{32'h8, 32'h0, 32'h80000000, 32'hFFFFFFFE, 32'h0, 32'h7, 32'h11, 32'h0};
    logic ec[8] = '{0, 1, 0, 0, 1, 1, 0, 1};
    logic eo[8] = '{0, 0, 1, 0, 0, 0, 0, 1};
    logic ez[8] = '{0, 1, 0, 0, 1, 0, 0, 1};
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 a = va[i]; b = vb[i]; cin = vc[i]; sub = vs[i]; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL dir%0d_in_ready got %b want 1", i, in_ready); end
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL dir%0d_latency got out_valid %b want 0", i, out_valid); end
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL dir%0d_out_valid got %b want 1", i, out_valid); end
      n_cmp++; if ({cout, sum} !== {ec[i], es[i]}) begin n_bad++; $display("FAIL dir%0d_result got %b/%h want %b/%h", i, cout, sum, ec[i], es[i]); end
`ifdef CLA_FLAGS_EN
      n_cmp++; if ({ovf, zero} !== {eo[i], ez[i]}) begin n_bad++; $display("FAIL dir%0d_flags got ovf/zero %b%b want %b%b", i, ovf, zero, eo[i], ez[i]); end
`else
      if (eo[i] === 1'bx || ez[i] === 1'bx) $display("note: flag table entry %0d undefined", i);
`endif
    end
  endtask

  task automatic test_back_to_back;
    int sent = 0, recv = 0, low = 0;
    logic hv = 1'b0;
    logic [32:0] held, exp;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1 in_valid = sent < 8; a = 32'(sent); b = 32'hFFFFFFFC; cin = 1'b0; sub = 1'b0;
      out_ready = !(n >= 3 && n <= 6);
      @(negedge clk);
      if (hv) begin
        n_cmp++; if (!out_valid || {cout, sum} !== held) begin n_bad++; $display("FAIL b2b_hold got %b/%h want 1/%h", out_valid, {cout, sum}, held); end
      end
      hv = out_valid & !out_ready;
      held = {cout, sum};
      if (in_valid && !in_ready) begin
        low++;
        n_cmp++; if (sent - recv != 2) begin n_bad++; $display("FAIL b2b_inflight got %0d want 2", sent - recv); end
      end
      if (out_valid && out_ready) begin
        exp = 33'(recv) + 33'h0FFFFFFFC;
        n_cmp++; if ({cout, sum} !== exp) begin n_bad++; $display("FAIL b2b_result%0d got %h want %h", recv, {cout, sum}, exp); end
        recv++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++; if (recv != 8) begin n_bad++; $display("FAIL b2b_count got %0d want 8", recv); end
    n_cmp++; if (low == 0) begin n_bad++; $display("FAIL b2b_backpressure got in_ready low %0d cycles want >0", low); end
  endtask

  task automatic test_reset_flush;
    @(posedge clk);
    #1 a = 32'h1; b = 32'h2; cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 a = 32'h3; b = 32'h4; rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_out_valid%0d got %b want 0", i, out_valid); end
      @(negedge clk);
    end
    @(posedge clk);
    #1 a = 32'h9; b = 32'h6; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (!out_valid || {cout, sum} !== 33'hF) begin n_bad++; $display("FAIL flush_recover got %b/%h want 1/00000000f", out_valid, {cout, sum}); end
  endtask

  task automatic test_random;
    logic [32:0] q[$];
    logic [32:0] held, exp;
    logic hv = 1'b0;
    int sent = 0, recv = 0;
    for (int n = 0; n < 40000 && recv < 10000; n++) begin
      @(posedge clk);
      #1 in_valid = (sent < 10000) && ($urandom_range(0, 3) != 0);
      a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      out_ready = $urandom_range(0, 3) != 0;
      @(negedge clk);
      if (hv) begin
        n_cmp++; if (!out_valid || {cout, sum} !== held) begin n_bad++; $display("FAIL rnd_hold got %b/%h want 1/%h", out_valid, {cout, sum}, held); end
      end
      hv = out_valid & !out_ready;
      held = {cout, sum};
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin n_bad++; $display("FAIL rnd_spurious got result %h want none", {cout, sum}); end
        else begin
          exp = q.pop_front();
          if ({cout, sum} !== exp) begin n_bad++; $display("FAIL rnd_result%0d got %h want %h", recv, {cout, sum}, exp); end
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        q.push_back(sub ? {1'b0, a} + {1'b0, ~b} + 33'd1 : {1'b0, a} + {1'b0, b} + {32'd0, cin});
        sent++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++; if (recv != 10000 || q.size() != 0) begin n_bad++; $display("FAIL rnd_count got %0d left %0d want 10000 left 0", recv, q.size()); end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_reset_flush;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
